// File: rtl/imm_gen_pipe.sv
// Pipelined RV32/RV64 immediate generator with a 2-entry skid buffer toward execute.
// Define IMM_ILLEGAL_DET_EN to add the registered out_illegal flag.
module imm_gen_pipe #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned AUTO_FMT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ins,
    input  logic [XLEN-1:0] in_pc,
    input  logic [2:0]      in_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_target
`ifdef IMM_ILLEGAL_DET_EN
    ,
    output logic            out_illegal
`endif
);

    typedef struct packed {
`ifdef IMM_ILLEGAL_DET_EN
        logic            ill;
`endif
        logic [2:0]      fmt;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] tgt;
    } payload_t;

    logic [2:0]      w_auto_fmt;
    logic [2:0]      w_fmt;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic            w_accept;
    payload_t        w_res;

    payload_t        r_out;
    payload_t        r_skid;
    logic            r_out_valid;
    logic            r_skid_valid;

    always_comb begin
        case (in_ins[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0011011: w_auto_fmt = 3'b000;
            7'b0100011:                                                 w_auto_fmt = 3'b001;
            7'b1100011:                                                 w_auto_fmt = 3'b010;
            7'b0110111, 7'b0010111:                                     w_auto_fmt = 3'b011;
            7'b1101111:                                                 w_auto_fmt = 3'b100;
            7'b0110011, 7'b0111011:                                     w_auto_fmt = 3'b101;
            default:                                                    w_auto_fmt = 3'b111;
        endcase
    end

    always_comb begin
        if (AUTO_FMT != 0) w_fmt = w_auto_fmt;
        else               w_fmt = in_sel;
    end

    always_comb begin
        case (w_fmt)
            3'b000:  w_imm32 = {{20{in_ins[31]}}, in_ins[31:20]};
            3'b001:  w_imm32 = {{20{in_ins[31]}}, in_ins[31:25], in_ins[11:7]};
            3'b010:  w_imm32 = {{19{in_ins[31]}}, in_ins[31], in_ins[7], in_ins[30:25],
                                in_ins[11:8], 1'b0};
            3'b011:  w_imm32 = {in_ins[31:12], 12'b0};
            3'b100:  w_imm32 = {{11{in_ins[31]}}, in_ins[31], in_ins[19:12], in_ins[20],
                                in_ins[30:21], 1'b0};
            default: w_imm32 = 32'b0;
        endcase
    end

    always_comb begin
        w_res     = '0;
        w_res.fmt = w_fmt;
        w_res.pc  = in_pc;
`ifdef IMM_ILLEGAL_DET_EN
        w_res.ill = (w_fmt == 3'b111) || (in_ins[1:0] != 2'b11);
        // Illegal words pass through with a zero immediate so target equals pc.
        w_imm     = w_res.ill ? '0 : XLEN'($signed(w_imm32));
`else
        w_imm     = XLEN'($signed(w_imm32));
`endif
        w_res.imm = w_imm;
        w_res.tgt = in_pc + w_imm;
    end

    assign in_ready = !r_skid_valid;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out        <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out        <= '0;
            r_skid       <= '0;
        end else if (!r_out_valid || out_ready) begin
            // Output slot frees up: skid has priority so order is preserved.
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_accept;
                if (w_accept) r_out <= w_res;
            end
        end else if (w_accept) begin
            r_skid       <= w_res;
            r_skid_valid <= 1'b1;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_imm    = r_out.imm;
    assign out_fmt    = r_out.fmt;
    assign out_pc     = r_out.pc;
    assign out_target = r_out.tgt;
`ifdef IMM_ILLEGAL_DET_EN
    assign out_illegal = r_out.ill;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed test-plan steps plus randomized traffic
// checked against an arithmetic reference model and an in-order scoreboard.
module tb_imm_gen_pipe;
    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_ins;
    logic [XLEN-1:0] in_pc;
    logic [2:0]      in_sel;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_target;
`ifdef IMM_ILLEGAL_DET_EN
    logic            out_illegal;
`endif

    imm_gen_pipe #(.XLEN(XLEN), .AUTO_FMT(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ins     (in_ins),
        .in_pc      (in_pc),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_imm    (out_imm),
        .out_fmt    (out_fmt),
        .out_pc     (out_pc),
        .out_target (out_target)
`ifdef IMM_ILLEGAL_DET_EN
        ,
        .out_illegal(out_illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] tgt;
        logic            ill;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   n_out = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: immediates assembled as integer sums of instruction fields, then wrapped.
    function automatic exp_t model(input logic [31:0] ins, input logic [XLEN-1:0] pc);
        exp_t            e;
        longint          v;
        longint          t;
        longint unsigned u;
        logic [6:0]      op;
        u  = longint'(ins);
        op = ins[6:0];
        case (op)
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0011011: e.fmt = 3'd0;
            7'b0100011: e.fmt = 3'd1;
            7'b1100011: e.fmt = 3'd2;
            7'b0110111, 7'b0010111: e.fmt = 3'd3;
            7'b1101111: e.fmt = 3'd4;
            7'b0110011, 7'b0111011: e.fmt = 3'd5;
            default: e.fmt = 3'd7;
        endcase
        v = 0;
        case (e.fmt)
            3'd0: begin v = longint'(u >> 20); if (v >= 2048) v -= 4096; end
            3'd1: begin
                v = longint'(((u >> 25) << 5) + ((u >> 7) % 32));
                if (v >= 2048) v -= 4096;
            end
            3'd2: begin
                v = longint'(((u >> 31) % 2) * 4096 + ((u >> 7) % 2) * 2048
                             + ((u >> 25) % 64) * 32 + ((u >> 8) % 16) * 2);
                if (v >= 4096) v -= 8192;
            end
            3'd3: begin
                v = longint'((u >> 12) * 4096);
                if (v >= 64'h8000_0000) v -= 64'h1_0000_0000;
            end
            3'd4: begin
                v = longint'(((u >> 31) % 2) * 1048576 + ((u >> 12) % 256) * 4096
                             + ((u >> 20) % 2) * 2048 + ((u >> 21) % 1024) * 2);
                if (v >= 1048576) v -= 2097152;
            end
            default: v = 0;
        endcase
        e.ill = (e.fmt == 3'd7) || ((u % 4) != 3);
        if (e.ill) v = 0;
        t     = longint'(pc) + v;
        e.imm = v[XLEN-1:0];
        e.pc  = pc;
        e.tgt = t[XLEN-1:0];
        return e;
    endfunction

    // One clock: score transfers at the coming edge, then advance to edge+1.
    task automatic tick();
        logic            fi;
        logic            fo;
        logic            stall;
        logic [XLEN-1:0] h_imm;
        logic [XLEN-1:0] h_pc;
        logic [XLEN-1:0] h_tgt;
        logic [2:0]      h_fmt;
        exp_t            e;
        fi    = in_valid && in_ready;
        fo    = out_valid && out_ready;
        stall = out_valid && !out_ready && !flush && rst_n;
        h_imm = out_imm; h_pc = out_pc; h_tgt = out_target; h_fmt = out_fmt;
        if (fo) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", {63'b0, out_valid}, 64'd0);
            end else begin
                e = sb.pop_front();
                n_out++;
                check("sb_imm", 64'(out_imm), 64'(e.imm));
                check("sb_fmt", 64'(out_fmt), 64'(e.fmt));
                check("sb_pc", 64'(out_pc), 64'(e.pc));
                check("sb_target", 64'(out_target), 64'(e.tgt));
`ifdef IMM_ILLEGAL_DET_EN
                check("sb_illegal", 64'(out_illegal), 64'(e.ill));
`endif
            end
        end
        if (flush) sb.delete();
        else if (fi) begin
            sb.push_back(model(in_ins, in_pc));
            n_acc++;
        end
        @(posedge clk);
        #1;
        if (stall) begin
            check("stall_valid", {63'b0, out_valid}, 64'd1);
            check("stall_imm", 64'(out_imm), 64'(h_imm));
            check("stall_fmt", 64'(out_fmt), 64'(h_fmt));
            check("stall_pc", 64'(out_pc), 64'(h_pc));
            check("stall_target", 64'(out_target), 64'(h_tgt));
        end
    endtask

    task automatic send1(input logic [31:0] ins, input logic [XLEN-1:0] pc,
                         input logic [XLEN-1:0] imm, input logic [2:0] fmt,
                         input logic [XLEN-1:0] tgt, input string tag);
        in_valid = 1'b1; in_ins = ins; in_pc = pc;
        tick();
        in_valid = 1'b0;
        check({tag, "_valid"}, {63'b0, out_valid}, 64'd1);
        check({tag, "_imm"}, 64'(out_imm), 64'(imm));
        check({tag, "_fmt"}, 64'(out_fmt), 64'(fmt));
        check({tag, "_target"}, 64'(out_target), 64'(tgt));
        tick();
    endtask

    logic [6:0]  ops [12] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0011011,
                              7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                              7'b0110011, 7'b0111011};
    logic [31:0] src [4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        int out0;
        int k;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_ins = '0; in_pc = '0; in_sel = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
        check("rst_imm", 64'(out_imm), 64'd0);
        check("rst_target", 64'(out_target), 64'd0);
        rst_n = 1'b1;

        send1(32'hFFF00093, 32'h0,   32'hFFFFFFFF, 3'd0, 32'hFFFFFFFF, "dir_i");
        send1(32'h123452B7, 32'h40,  32'h12345000, 3'd3, 32'h12345040, "dir_u");
        send1(32'hFFDFF06F, 32'h100, 32'hFFFFFFFC, 3'd4, 32'h000000FC, "dir_j");
        send1(32'h00000463, 32'h200, 32'h00000008, 3'd2, 32'h00000208, "dir_b");
        send1(32'hFE112E23, 32'h10,  32'hFFFFFFFC, 3'd1, 32'h0000000C, "dir_s");
        send1(32'h00B50533, 32'h300, 32'h0,        3'd5, 32'h300,      "dir_r");
`ifdef IMM_ILLEGAL_DET_EN
        in_valid = 1'b1; in_ins = 32'h0; in_pc = 32'h44;
        tick();
        in_valid = 1'b0;
        check("ill_flag", 64'(out_illegal), 64'd1);
        check("ill_fmt", 64'(out_fmt), 64'd7);
        check("ill_target", 64'(out_target), 64'h44);
        tick();
`endif

        // Backpressure: 4-instruction stream, out_ready low for 3 cycles.
        src = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
        acc0 = n_acc; out0 = n_out;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_ins = src[n_acc - acc0]; in_pc = 32'h1000 + 32'(4 * (n_acc - acc0));
            tick();
        end
        check("bp_accepts", 64'(n_acc - acc0), 64'd2);
        check("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
        out_ready = 1'b1;
        k = 0;
        while (((n_acc - acc0) < 4 || sb.size() != 0) && k < 20) begin
            in_valid = (n_acc - acc0) < 4;
            if (in_valid) begin
                in_ins = src[n_acc - acc0]; in_pc = 32'h1000 + 32'(4 * (n_acc - acc0));
            end
            tick();
            k++;
        end
        in_valid = 1'b0;
        check("bp_drained", 64'(n_out - out0), 64'd4);
        check("bp_in_ready_back", {63'b0, in_ready}, 64'd1);

        // Flush with two buffered entries and a concurrent input.
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1; in_ins = src[c]; in_pc = 32'h2000 + 32'(4 * c);
            tick();
        end
        check("fl_full", {63'b0, in_ready}, 64'd0);
        flush = 1'b1; in_valid = 1'b1; in_ins = src[2];
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("fl_out_valid", {63'b0, out_valid}, 64'd0);
        check("fl_in_ready", {63'b0, in_ready}, 64'd1);
        repeat (3) tick();

        // Randomized traffic with occasional flush.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 49) == 0);
            in_ins    = $urandom();
            if ($urandom_range(0, 9) != 0) in_ins[6:0] = ops[$urandom_range(0, 11)];
            in_pc     = $urandom();
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        k = 0;
        while (sb.size() != 0 && k < 10) begin
            tick();
            k++;
        end
        check("rand_drained", 64'(sb.size()), 64'd0);

        // Reset mid-stall clears everything asynchronously.
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1; in_ins = src[c]; in_pc = 32'h3000;
            tick();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mrst_out_valid", {63'b0, out_valid}, 64'd0);
        check("mrst_in_ready", {63'b0, in_ready}, 64'd1);
        check("mrst_imm", 64'(out_imm), 64'd0);
        check("mrst_fmt", 64'(out_fmt), 64'd0);
        check("mrst_pc", 64'(out_pc), 64'd0);
        check("mrst_target", 64'(out_target), 64'd0);
        sb.delete();
        rst_n = 1'b1; out_ready = 1'b1;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
